// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the run-time programmable clock divider.
package clk_div_pkg;

  typedef enum logic [0:0] {IDLE, RUN} ctrl_state_t;

  localparam int unsigned DIV_MIN = 2;

  // High-phase length of a period; odd divisors get the extra cycle high.
  function automatic int unsigned hi_len(input int unsigned div);
    return div - div / 2;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter plus registered clk_out and tick generation for clk_div_ctrl.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             run_nxt,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] div_nxt,
  output logic             boundary,
  output logic             tick,
  output logic             clk_out
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;

  assign boundary = run && (cnt_q == div - DIV_W'(1));
  assign tick     = boundary;
  assign clk_out  = clk_out_q;

  // clk_out is registered from next-cycle state so it follows cnt with no lag.
  always_comb begin
    cnt_d = '0;
    if (run_nxt && run && !boundary) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
    clk_out_d = run_nxt && (32'(cnt_d) < hi_len(32'(div_nxt)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Glitch-free programmable clock divider controller: FSM, config handshake, pending divisor.
// Optional completed-period counter on tick_cnt when CLK_DIV_CTRL_TICK_CNT_EN is defined.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DEF_DIV = 6
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  ,
  parameter int unsigned CNT_W   = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  ,
  output logic [CNT_W-1:0] tick_cnt
`endif
);

  ctrl_state_t      state_q, state_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pnd_div_q, pnd_div_d;
  logic             pend_q, pend_d;
  logic             cfg_err_q, cfg_err_d;
  logic             boundary;
  logic             accept;
  logic             div_ok;

  assign cfg_ready = !pend_q;
  assign cfg_err   = cfg_err_q;
  assign accept    = cfg_valid && cfg_ready;
  assign div_ok    = cfg_div >= DIV_W'(DIV_MIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // en is only looked at in IDLE or in the boundary cycle of a period.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (en) state_d = RUN;
      RUN:  if (boundary && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  // A request landing on the boundary takes effect immediately, so pend never sees it.
  always_comb begin
    cur_div_d = cur_div_q;
    pnd_div_d = pnd_div_q;
    pend_d    = pend_q;
    cfg_err_d = accept && !div_ok;
    if (boundary && pend_q) begin
      cur_div_d = pnd_div_q;
      pend_d    = 1'b0;
    end
    if (accept && div_ok) begin
      if (state_q == IDLE || boundary) begin
        cur_div_d = cfg_div;
      end else begin
        pnd_div_d = cfg_div;
        pend_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_div_q <= DIV_W'(DEF_DIV);
      pnd_div_q <= '0;
      pend_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cur_div_q <= cur_div_d;
      pnd_div_q <= pnd_div_d;
      pend_q    <= pend_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  clk_div_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .run      (state_q == RUN),
    .run_nxt  (state_d == RUN),
    .div      (cur_div_q),
    .div_nxt  (cur_div_d),
    .boundary (boundary),
    .tick     (tick),
    .clk_out  (clk_out)
  );

`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  logic [CNT_W-1:0] tick_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= tick_cnt_q + CNT_W'(1);
    end
  end

  assign tick_cnt = tick_cnt_q;
`endif

endmodule
